xd_pulse_spacer: RTL and testbench

- Single-domain pulse conditioner placed directly upstream of the cross-domain pulse block (xd) when crossing from a fast to a slow domain.
- Counts input pulse events and re-emits them as single-cycle pulses spaced at least GAP cycles apart.
- Burst or back-to-back pulses therefore reach the destination domain intact instead of merging or vanishing.
- Reports backlog and overflow so the producer can throttle.

---
 rtl/xd_pkg.sv | 8 +
 rtl/xd_pulse_spacer_if.sv | 15 +
 rtl/xd_pulse_spacer.sv | 102 ++++++++++
 tb/tb_xd_pulse_spacer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/xd_pkg.sv
// rtl/xd_pkg.sv - shared types and defaults for the xd pulse spacer
package xd_pkg;

  typedef enum logic {IDLE, HOLD} xd_spacer_state_t;

  localparam int XD_GAP_DEFAULT = 6;

endpackage

// File: rtl/xd_pulse_spacer_if.sv
// rtl/xd_pulse_spacer_if.sv - event input and spaced pulse/status outputs of xd_pulse_spacer
interface xd_pulse_spacer_if #(
  parameter int CNTW = 4
);

  logic            i;
  logic            o;
  logic [CNTW-1:0] pending;
  logic            busy;
  logic            overflow;

  modport master (output i, input o, pending, busy, overflow);
  modport slave  (input i, output o, pending, busy, overflow);

endinterface

// File: rtl/xd_pulse_spacer.sv
// rtl/xd_pulse_spacer.sv - re-emits input events as single-cycle pulses spaced GAP cycles apart
// Define XD_SPACER_EDGE_EN to count rising edges of i instead of every high cycle.
module xd_pulse_spacer
  import xd_pkg::*;
#(
  parameter int GAP  = XD_GAP_DEFAULT,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  xd_pulse_spacer_if.slave sp
);

  localparam int            CW         = $clog2(GAP);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(GAP - 1);
  localparam logic [CNTW-1:0] PEND_MAX = {CNTW{1'b1}};

  xd_spacer_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNTW-1:0]  pending_q, pending_d;
  logic             o_q, o_d;
  logic             overflow_q, overflow_d;
  logic             ev;
  logic             emit;
  logic             drop;
  logic             accept;

`ifdef XD_SPACER_EDGE_EN
  logic i_q, i_d;

  assign i_d = sp.i;
  assign ev  = sp.i & ~i_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= 1'b0;
    end else begin
      i_q <= i_d;
    end
  end
`else
  assign ev = sp.i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;

    if (state_q == IDLE) begin
      if (pending_q != '0) begin
        emit    = 1'b1;
        cnt_d   = CNT_RELOAD;
        state_d = HOLD;
      end
    end else begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else if (pending_q != '0) begin
        emit  = 1'b1;
        cnt_d = CNT_RELOAD;
      end else begin
        state_d = IDLE;
      end
    end

    // A full backlog still absorbs an event when an emission frees a slot on the same edge.
    drop       = ev & (pending_q == PEND_MAX) & ~emit;
    accept     = ev & ~drop;
    overflow_d = drop;
    o_d        = emit;

    pending_d = pending_q;
    if (accept && !emit) begin
      pending_d = pending_q + CNTW'(1);
    end else if (emit && !accept) begin
      pending_d = pending_q - CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      o_q        <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      o_q        <= o_d;
      overflow_q <= overflow_d;
    end
  end

  assign sp.o        = o_q;
  assign sp.pending  = pending_q;
  assign sp.overflow = overflow_q;
  assign sp.busy     = (pending_q != '0) || (state_q == HOLD);

endmodule

// File: tb/tb_xd_pulse_spacer.sv
// tb/tb_xd_pulse_spacer.sv - self-checking bench for xd_pulse_spacer (GAP=6, CNTW=4)
module tb_xd_pulse_spacer;

  localparam int GAP  = 6;
  localparam int CNTW = 4;
  localparam int PMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xd_pulse_spacer_if #(.CNTW(CNTW)) sp_if ();

  xd_pulse_spacer #(.GAP(GAP), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .sp  (sp_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: backlog count plus time of the last emitted pulse
  int cyc       = 0;
  int pend_m    = 0;
  int last_m    = -1000;
  bit prev_i_m  = 1'b0;
  bit o_m       = 1'b0;
  bit ov_m      = 1'b0;
  bit busy_m    = 1'b0;

  int last_seen = -1;
  int o_cnt     = 0;
  int ov_cnt    = 0;
  int max_pend  = 0;
  int o_cycles[$];

  typedef struct {
    bit   i;
    bit   r;
    bit   exp_o;
    int   exp_pend;
    bit   exp_busy;
    bit   exp_ov;
  } vec_t;

  vec_t vecs[11];

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endfunction

  task automatic step(input bit iv, input bit rv);
    bit ev;
    bit em;
    @(negedge clk);
    sp_if.i = iv;
    rst     = rv;
    @(posedge clk);
    if (rv) begin
      pend_m   = 0;
      last_m   = -1000;
      o_m      = 1'b0;
      ov_m     = 1'b0;
      prev_i_m = 1'b0;
    end else begin
`ifdef XD_SPACER_EDGE_EN
      ev = iv && !prev_i_m;
`else
      ev = iv;
`endif
      prev_i_m = iv;
      em   = (pend_m > 0) && (cyc - last_m >= GAP - 1);
      ov_m = ev && (pend_m == PMAX) && !em;
      pend_m = pend_m + ((ev && !ov_m) ? 1 : 0) - (em ? 1 : 0);
      o_m  = em;
      if (em) last_m = cyc + 1;
    end
    cyc++;
    busy_m = (pend_m > 0) || (cyc - last_m <= GAP - 1);
    #1;
    check("o", int'(sp_if.o), int'(o_m));
    check("pending", int'(sp_if.pending), pend_m);
    check("busy", int'(sp_if.busy), int'(busy_m));
    check("overflow", int'(sp_if.overflow), int'(ov_m));
    if (rv) last_seen = -1;
    if (sp_if.o) begin
      if (last_seen >= 0) check("spacing_ok", int'(cyc - last_seen >= GAP), 1);
      last_seen = cyc;
      o_cnt++;
      o_cycles.push_back(cyc);
    end
    if (sp_if.overflow) ov_cnt++;
    if (int'(sp_if.pending) > max_pend) max_pend = int'(sp_if.pending);
  endtask

  initial begin
    int n0;
    int exp_q[$];

    sp_if.i = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // single pulse, then an event coinciding with reset
    for (int k = 0; k < 11; k++) begin
      step(vecs[k].i, vecs[k].r);
      check("tbl_o", int'(sp_if.o), int'(vecs[k].exp_o));
      check("tbl_pending", int'(sp_if.pending), vecs[k].exp_pend);
      check("tbl_busy", int'(sp_if.busy), int'(vecs[k].exp_busy));
      check("tbl_overflow", int'(sp_if.overflow), int'(vecs[k].exp_ov));
    end

    // three-cycle burst
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    o_cycles.delete();
    n0 = cyc;
    step(1'b1, 1'b0);
    check("burst_pend_n1", int'(sp_if.pending), 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
`ifdef XD_SPACER_EDGE_EN
    check("burst_pend_n3", int'(sp_if.pending), 0);
    exp_q = '{n0 + 2};
`else
    check("burst_pend_n3", int'(sp_if.pending), 2);
    exp_q = '{n0 + 2, n0 + 8, n0 + 14};
`endif
    for (int k = 0; k < 25; k++) step(1'b0, 1'b0);
    check("burst_npulses", o_cycles.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < o_cycles.size(); k++)
      check("burst_o_cycle", o_cycles[k], exp_q[k]);
    check("burst_idle_busy", int'(sp_if.busy), 0);

    // saturation: 25 distinct events in alternating cycles
    step(1'b0, 1'b1);
    o_cnt = 0; ov_cnt = 0; max_pend = 0;
    for (int k = 0; k < 50; k++) step(k % 2 == 0, 1'b0);
    for (int k = 0; k < 200; k++) step(1'b0, 1'b0);
    check("sat_max_pending", max_pend, PMAX);
    check("sat_has_overflow", int'(ov_cnt > 0), 1);
    check("sat_events_total", o_cnt + ov_cnt, 25);
    check("sat_drained", int'(sp_if.busy), 0);

    // reset while in HOLD with a backlog
    step(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(k % 2 == 0, 1'b0);
    check("rmid_backlog", int'(sp_if.pending != '0), 1);
    step(1'b0, 1'b1);
    check("rmid_o", int'(sp_if.o), 0);
    check("rmid_pending", int'(sp_if.pending), 0);
    check("rmid_busy", int'(sp_if.busy), 0);
    o_cnt = 0;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
    check("rmid_no_stale", o_cnt, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 40), ($urandom_range(0, 199) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
